// File: rtl/sys_ctrl_rx.sv
// sys_ctrl_rx: command controller behind the UART receiver.
// Parses 2/3-byte command frames from the RX byte stream:
//   0xAA addr data -> register-file write
//   0xBB addr      -> register-file read, read data forwarded to the UART TX
//   0xCC cfg       -> receiver parity / prescale configuration
// Also keeps a saturating 8-bit error counter.
//
// Optional feature: define SYS_CTRL_TIMEOUT_EN to abort partial frames after
// TIMEOUT_CYC cycles without a byte (RD_WAIT/TX_WAIT are never timed).
//
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   rx_p_data, rx_d_valid      received byte and its one-cycle valid pulse
//   rx_frame_err               one-cycle pulse per dropped (bad parity/stop) byte
//   rf_addr, rf_wr_data        register-file address / write data
//   rf_wr_en, rf_rd_en         one-cycle register-file strobes
//   rf_rd_data, rf_rd_valid    register-file read return
//   tx_p_data, tx_d_valid      byte and one-cycle request to the transmitter
//   tx_busy                    transmitter occupied
//   PAR_EN, PAR_TYP, Prescale  receiver configuration
//   err_cnt                    saturating error count
module sys_ctrl_rx #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_p_data,
    input  logic              rx_d_valid,
    input  logic              rx_frame_err,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_wr_data,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    input  logic [7:0]        rf_rd_data,
    input  logic              rf_rd_valid,
    output logic [7:0]        tx_p_data,
    output logic              tx_d_valid,
    input  logic              tx_busy,
    output logic              PAR_EN,
    output logic              PAR_TYP,
    output logic [5:0]        Prescale,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ADDR  = 3'd1,
        WR_DATA  = 3'd2,
        RD_ADDR  = 3'd3,
        RD_WAIT  = 3'd4,
        TX_WAIT  = 3'd5,
        CFG_DATA = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [7:0]        rf_wr_data_q, rf_wr_data_d;
    logic              rf_wr_en_q, rf_wr_en_d;
    logic              rf_rd_en_q, rf_rd_en_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        tx_p_data_q, tx_p_data_d;
    logic              tx_d_valid_q, tx_d_valid_d;
    logic              par_en_q, par_en_d;
    logic              par_typ_q, par_typ_d;
    logic [5:0]        prescale_q, prescale_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              err_inc_c;
    logic              addr_ok_c;
    logic              tmo_hit_c;

    // Address byte is valid only if all bits above the address field are zero
    assign addr_ok_c = (rx_p_data >> ADDR_W) == 8'd0;

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timed_c;
    logic             quiet_c;

    assign timed_c = (state_q == WR_ADDR) || (state_q == WR_DATA) ||
                     (state_q == RD_ADDR) || (state_q == CFG_DATA);
    assign quiet_c = !rx_d_valid && !rx_frame_err;
    // Fires in the TIMEOUT_CYC-th consecutive byte-less cycle of a partial frame
    assign tmo_hit_c = timed_c && quiet_c &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

    // Count byte-less cycles; any byte or leaving the timed states restarts it
    always_comb begin
        tmo_cnt_d = '0;
        if (timed_c && quiet_c && !tmo_hit_c) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    // No timeout: partial frames wait indefinitely (parameter kept for a uniform interface)
    assign tmo_hit_c = (TIMEOUT_CYC == 0) && 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rd_data_d    = rd_data_q;
        tx_p_data_d  = tx_p_data_q;
        tx_d_valid_d = 1'b0;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        prescale_d   = prescale_q;
        err_inc_c    = 1'b0;

        // A frame error discards any coincident byte and the partial frame
        if (rx_frame_err || tmo_hit_c) begin
            state_d   = IDLE;
            err_inc_c = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_d_valid) begin
                        if (rx_p_data == 8'hAA) begin
                            state_d = WR_ADDR;
                        end else if (rx_p_data == 8'hBB) begin
                            state_d = RD_ADDR;
                        end else if (rx_p_data == 8'hCC) begin
                            state_d = CFG_DATA;
                        end else begin
                            err_inc_c = 1'b1;
                        end
                    end
                end
                WR_ADDR: begin
                    if (rx_d_valid) begin
                        if (addr_ok_c) begin
                            rf_addr_d = rx_p_data[ADDR_W-1:0];
                            state_d   = WR_DATA;
                        end else begin
                            state_d   = IDLE;
                            err_inc_c = 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (rx_d_valid) begin
                        rf_wr_data_d = rx_p_data;
                        rf_wr_en_d   = 1'b1;
                        state_d      = IDLE;
                    end
                end
                RD_ADDR: begin
                    if (rx_d_valid) begin
                        if (addr_ok_c) begin
                            rf_addr_d  = rx_p_data[ADDR_W-1:0];
                            rf_rd_en_d = 1'b1;
                            state_d    = RD_WAIT;
                        end else begin
                            state_d   = IDLE;
                            err_inc_c = 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    // Bytes here are overruns: counted, state kept
                    err_inc_c = rx_d_valid;
                    if (rf_rd_valid) begin
                        rd_data_d = rf_rd_data;
                        state_d   = TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    err_inc_c = rx_d_valid;
                    if (!tx_busy) begin
                        tx_p_data_d  = rd_data_q;
                        tx_d_valid_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
                CFG_DATA: begin
                    if (rx_d_valid) begin
                        // A zero prescale is illegal: keep the old configuration
                        if (rx_p_data[7:2] != 6'd0) begin
                            par_en_d   = rx_p_data[0];
                            par_typ_d  = rx_p_data[1];
                            prescale_d = rx_p_data[7:2];
                        end else begin
                            err_inc_c = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Saturating error counter
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_inc_c && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            rf_addr_q    <= '0;
            rf_wr_data_q <= 8'd0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rd_data_q    <= 8'd0;
            tx_p_data_q  <= 8'd0;
            tx_d_valid_q <= 1'b0;
            par_en_q     <= 1'b1;
            par_typ_q    <= 1'b0;
            prescale_q   <= 6'd8;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rd_data_q    <= rd_data_d;
            tx_p_data_q  <= tx_p_data_d;
            tx_d_valid_q <= tx_d_valid_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            prescale_q   <= prescale_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign rf_addr    = rf_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign tx_p_data  = tx_p_data_q;
    assign tx_d_valid = tx_d_valid_q;
    assign PAR_EN     = par_en_q;
    assign PAR_TYP    = par_typ_q;
    assign Prescale   = prescale_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sys_ctrl_rx.sv
// Self-checking bench for sys_ctrl_rx: directed scenarios plus a randomized
// frame stream checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_sys_ctrl_rx;

    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned TIMEOUT_CYC = 64;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_p_data;
    logic              rx_d_valid;
    logic              rx_frame_err;
    logic [ADDR_W-1:0] rf_addr;
    logic [7:0]        rf_wr_data;
    logic              rf_wr_en;
    logic              rf_rd_en;
    logic [7:0]        rf_rd_data;
    logic              rf_rd_valid;
    logic [7:0]        tx_p_data;
    logic              tx_d_valid;
    logic              tx_busy;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic [5:0]        Prescale;
    logic [7:0]        err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    sys_ctrl_rx #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_p_data    (rx_p_data),
        .rx_d_valid   (rx_d_valid),
        .rx_frame_err (rx_frame_err),
        .rf_addr      (rf_addr),
        .rf_wr_data   (rf_wr_data),
        .rf_wr_en     (rf_wr_en),
        .rf_rd_en     (rf_rd_en),
        .rf_rd_data   (rf_rd_data),
        .rf_rd_valid  (rf_rd_valid),
        .tx_p_data    (tx_p_data),
        .tx_d_valid   (tx_d_valid),
        .tx_busy      (tx_busy),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .Prescale     (Prescale),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled on the falling edge
    logic [ADDR_W+7:0] wr_seen[$];
    logic [7:0]        tx_seen[$];
    int                rd_seen = 0;
    always @(negedge clk) begin
        if (rf_wr_en)   wr_seen.push_back({rf_addr, rf_wr_data});
        if (rf_rd_en)   rd_seen++;
        if (tx_d_valid) tx_seen.push_back(tx_p_data);
    end

    // Reference model state
    int       m_err;
    logic     m_par_en;
    logic     m_par_typ;
    logic [5:0] m_presc;

    function automatic void m_reset();
        m_err = 0; m_par_en = 1'b1; m_par_typ = 1'b0; m_presc = 6'd8;
    endfunction

    function automatic void m_err_inc();
        if (m_err < 255) m_err++;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_p_data = b; rx_d_valid = 1'b1;
        cyc(1);
        rx_d_valid = 1'b0; rx_p_data = 8'h00;
    endtask

    task automatic send_ferr(input logic [7:0] b, input logic with_byte);
        rx_p_data = b; rx_d_valid = with_byte; rx_frame_err = 1'b1;
        cyc(1);
        rx_d_valid = 1'b0; rx_frame_err = 1'b0; rx_p_data = 8'h00;
    endtask

    task automatic apply_reset();
        rst = 1'b0; rx_d_valid = 1'b0; rx_frame_err = 1'b0; rx_p_data = 8'h00;
        rf_rd_valid = 1'b0; rf_rd_data = 8'h00; tx_busy = 1'b0;
        cyc(2);
        rst = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({rf_wr_en, rf_rd_en, tx_d_valid} !== 3'b000) begin
            n_bad++; $display("FAIL reset_strobes: got %b expected 000", {rf_wr_en, rf_rd_en, tx_d_valid});
        end
        n_cmp++;
        if (err_cnt !== 8'd0) begin
            n_bad++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
        n_cmp++;
        if ({PAR_EN, PAR_TYP, Prescale} !== {1'b1, 1'b0, 6'd8}) begin
            n_bad++; $display("FAIL reset_cfg: got %b/%b/%0d expected 1/0/8", PAR_EN, PAR_TYP, Prescale);
        end
        n_cmp++;
        if ({rf_addr, rf_wr_data, tx_p_data} !== '0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", rf_addr, rf_wr_data, tx_p_data);
        end
    endtask

    task automatic test_write();
        int base;
        apply_reset();
        base = wr_seen.size();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        n_cmp++;
        if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'h5, 8'h3C}) begin
            n_bad++; $display("FAIL write_strobe: got en=%b addr=%h data=%h expected 1/5/3c", rf_wr_en, rf_addr, rf_wr_data);
        end
        cyc(1);
        n_cmp++;
        if (rf_wr_en !== 1'b0) begin
            n_bad++; $display("FAIL write_pulse_width: got %b expected 0", rf_wr_en);
        end
        cyc(3);
        n_cmp++;
        if (wr_seen.size() - base != 1 || {rf_addr, rf_wr_data} !== {4'h5, 8'h3C}) begin
            n_bad++; $display("FAIL write_count_hold: got %0d pulses addr=%h data=%h expected 1/5/3c", wr_seen.size() - base, rf_addr, rf_wr_data);
        end
    endtask

    task automatic test_read_busy();
        int rbase, tbase;
        apply_reset();
        tx_busy = 1'b1;
        rbase = rd_seen; tbase = tx_seen.size();
        send_byte(8'hBB); send_byte(8'h02);
        n_cmp++;
        if ({rf_rd_en, rf_addr} !== {1'b1, 4'h2}) begin
            n_bad++; $display("FAIL read_strobe: got en=%b addr=%h expected 1/2", rf_rd_en, rf_addr);
        end
        rf_rd_valid = 1'b1; rf_rd_data = 8'h5A;
        cyc(1);
        rf_rd_valid = 1'b0; rf_rd_data = 8'h00;
        cyc(20);
        n_cmp++;
        if (tx_seen.size() != tbase || rd_seen - rbase != 1) begin
            n_bad++; $display("FAIL read_busy_hold: got tx=%0d rd=%0d expected 0/1", tx_seen.size() - tbase, rd_seen - rbase);
        end
        tx_busy = 1'b0;
        cyc(1);
        n_cmp++;
        if ({tx_d_valid, tx_p_data} !== {1'b1, 8'h5A}) begin
            n_bad++; $display("FAIL read_tx: got valid=%b data=%h expected 1/5a", tx_d_valid, tx_p_data);
        end
        cyc(1);
        n_cmp++;
        if (tx_d_valid !== 1'b0 || tx_seen.size() - tbase != 1) begin
            n_bad++; $display("FAIL read_tx_once: got valid=%b count=%0d expected 0/1", tx_d_valid, tx_seen.size() - tbase);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        tx_busy = 1'b1;
        send_byte(8'hBB); send_byte(8'h03);
        send_byte(8'h11);                       // arrives in RD_WAIT
        rf_rd_valid = 1'b1; rf_rd_data = 8'h96;
        cyc(1);
        rf_rd_valid = 1'b0;
        send_byte(8'h22);                       // arrives in TX_WAIT
        tx_busy = 1'b0;
        cyc(1);
        n_cmp++;
        if ({tx_d_valid, tx_p_data, err_cnt} !== {1'b1, 8'h96, 8'd2}) begin
            n_bad++; $display("FAIL overrun: got valid=%b data=%h err=%0d expected 1/96/2", tx_d_valid, tx_p_data, err_cnt);
        end
    endtask

    task automatic test_config();
        apply_reset();
        send_byte(8'hCC); send_byte(8'h42);
        n_cmp++;
        if ({PAR_EN, PAR_TYP, Prescale} !== {1'b0, 1'b1, 6'd16}) begin
            n_bad++; $display("FAIL config_load: got %b/%b/%0d expected 0/1/16", PAR_EN, PAR_TYP, Prescale);
        end
        send_byte(8'hCC); send_byte(8'h01);
        n_cmp++;
        if ({PAR_EN, PAR_TYP, Prescale, err_cnt} !== {1'b0, 1'b1, 6'd16, 8'd1}) begin
            n_bad++; $display("FAIL config_zero_prescale: got %b/%b/%0d err=%0d expected 0/1/16 err=1", PAR_EN, PAR_TYP, Prescale, err_cnt);
        end
    endtask

    task automatic test_errors();
        int base;
        apply_reset();
        base = wr_seen.size();
        send_byte(8'h77);
        n_cmp++;
        if (err_cnt !== 8'd1) begin
            n_bad++; $display("FAIL err_opcode: got %0d expected 1", err_cnt);
        end
        send_byte(8'hAA); send_ferr(8'h00, 1'b0);
        n_cmp++;
        if (err_cnt !== 8'd2) begin
            n_bad++; $display("FAIL err_frame: got %0d expected 2", err_cnt);
        end
        send_byte(8'hAA); send_byte(8'h15);
        n_cmp++;
        if (err_cnt !== 8'd3 || rf_addr !== 4'h0) begin
            n_bad++; $display("FAIL err_bad_addr: got err=%0d addr=%h expected 3/0", err_cnt, rf_addr);
        end
        // Frame error coinciding with a byte: byte discarded, 0x3C then parsed as opcode
        send_byte(8'hAA); send_ferr(8'h05, 1'b1); send_byte(8'h3C);
        n_cmp++;
        if (err_cnt !== 8'd5 || wr_seen.size() != base) begin
            n_bad++; $display("FAIL err_coincident: got err=%0d writes=%0d expected 5/0", err_cnt, wr_seen.size() - base);
        end
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h99);
        cyc(1);
        n_cmp++;
        if (wr_seen.size() != base + 1 || {rf_addr, rf_wr_data} !== {4'h7, 8'h99}) begin
            n_bad++; $display("FAIL err_recover: got writes=%0d addr=%h data=%h expected 1/7/99", wr_seen.size() - base, rf_addr, rf_wr_data);
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        apply_reset();
        base = wr_seen.size();
        send_byte(8'hAA); send_byte(8'h05);
        rst = 1'b0; cyc(2); rst = 1'b1;
        cyc(1);
        n_cmp++;
        if ({rf_wr_en, rf_rd_en, tx_d_valid, err_cnt, rf_addr} !== '0) begin
            n_bad++; $display("FAIL midframe_reset: got strobes=%b err=%0d addr=%h expected 0", {rf_wr_en, rf_rd_en, tx_d_valid}, err_cnt, rf_addr);
        end
        send_byte(8'h3C);
        cyc(1);
        n_cmp++;
        if (err_cnt !== 8'd1 || wr_seen.size() != base) begin
            n_bad++; $display("FAIL midframe_discard: got err=%0d writes=%0d expected 1/0", err_cnt, wr_seen.size() - base);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] b;
        apply_reset();
        for (int i = 0; i < 260; i++) begin
            do b = 8'($urandom); while (b == 8'hAA || b == 8'hBB || b == 8'hCC);
            send_byte(b);
            if (i == 253) begin
                n_cmp++;
                if (err_cnt !== 8'd254) begin
                    n_bad++; $display("FAIL sat_before: got %0d expected 254", err_cnt);
                end
            end
        end
        n_cmp++;
        if (err_cnt !== 8'hFF) begin
            n_bad++; $display("FAIL sat_cap: got %0d expected 255", err_cnt);
        end
        send_byte(8'hAA); send_byte(8'h15);
        n_cmp++;
        if (err_cnt !== 8'hFF) begin
            n_bad++; $display("FAIL sat_hold: got %0d expected 255", err_cnt);
        end
    endtask

    task automatic test_timeout();
        int base;
        apply_reset();
        base = wr_seen.size();
`ifdef SYS_CTRL_TIMEOUT_EN
        send_byte(8'hAA);
        cyc(TIMEOUT_CYC - 2);
        n_cmp++;
        if (err_cnt !== 8'd0) begin
            n_bad++; $display("FAIL tmo_early: got %0d expected 0", err_cnt);
        end
        cyc(3);
        n_cmp++;
        if (err_cnt !== 8'd1) begin
            n_bad++; $display("FAIL tmo_fire: got %0d expected 1", err_cnt);
        end
        send_byte(8'h05);                       // back in IDLE, so an invalid opcode
        n_cmp++;
        if (err_cnt !== 8'd2) begin
            n_bad++; $display("FAIL tmo_idle: got %0d expected 2", err_cnt);
        end
        // Each byte restarts the timer
        send_byte(8'hAA); cyc(TIMEOUT_CYC - 5);
        send_byte(8'h06); cyc(TIMEOUT_CYC - 5);
        send_byte(8'h44); cyc(1);
        n_cmp++;
        if (err_cnt !== 8'd2 || wr_seen.size() != base + 1) begin
            n_bad++; $display("FAIL tmo_restart: got err=%0d writes=%0d expected 2/1", err_cnt, wr_seen.size() - base);
        end
`else
        send_byte(8'hAA); cyc(4 * TIMEOUT_CYC);
        send_byte(8'h06); cyc(4 * TIMEOUT_CYC);
        send_byte(8'h44); cyc(1);
        n_cmp++;
        if (err_cnt !== 8'd0 || wr_seen.size() != base + 1) begin
            n_bad++; $display("FAIL no_timeout: got err=%0d writes=%0d expected 0/1", err_cnt, wr_seen.size() - base);
        end
`endif
    endtask

    task automatic test_random();
        logic [ADDR_W+7:0] exp_wr[$];
        logic [7:0]        exp_tx[$];
        int wbase, tbase, rbase, exp_rd, kind, lat, hold, n;
        logic [7:0] a, d, c;
        apply_reset();
        wbase = wr_seen.size(); tbase = tx_seen.size(); rbase = rd_seen; exp_rd = 0;
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 4);
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            d = 8'($urandom);
            case (kind)
                0: begin
                    send_byte(8'hAA); send_byte(a);
                    if (a < 16) begin
                        send_byte(d); exp_wr.push_back({a[3:0], d});
                    end else m_err_inc();
                end
                1: begin
                    send_byte(8'hBB); send_byte(a);
                    if (a < 16) begin
                        exp_rd++;
                        lat = $urandom_range(0, 4); hold = $urandom_range(0, 4);
                        cyc(lat);
                        tx_busy = (hold != 0);
                        rf_rd_valid = 1'b1; rf_rd_data = d;
                        cyc(1);
                        rf_rd_valid = 1'b0; rf_rd_data = 8'h00;
                        cyc(hold);
                        tx_busy = 1'b0;
                        exp_tx.push_back(d);
                        n = tx_seen.size();
                        for (int i = 0; i < 50 && tx_seen.size() == n; i++) cyc(1);
                        if (tx_seen.size() == n) begin
                            n_cmp++; n_bad++;
                            $display("FAIL rand_tx_timeout: got no tx_d_valid expected data %h", d);
                        end
                    end else m_err_inc();
                end
                2: begin
                    c = ($urandom_range(0, 3) == 0) ? {6'd0, d[1:0]} : d;
                    send_byte(8'hCC); send_byte(c);
                    if (c[7:2] != 6'd0) begin
                        m_par_en = c[0]; m_par_typ = c[1]; m_presc = c[7:2];
                    end else m_err_inc();
                end
                3: begin
                    if (d == 8'hAA || d == 8'hBB || d == 8'hCC) d = 8'h00;
                    send_byte(d); m_err_inc();
                end
                default: begin
                    if (d[0]) send_byte(d[1] ? 8'hAA : 8'hCC);
                    send_ferr(a, d[2]); m_err_inc();
                end
            endcase
            cyc($urandom_range(0, 2));
            n_cmp++;
            if (err_cnt !== 8'(m_err)) begin
                n_bad++; $display("FAIL rand_err_cnt frame %0d kind %0d: got %0d expected %0d", f, kind, err_cnt, m_err);
            end
        end
        cyc(2);
        n_cmp++;
        if ({PAR_EN, PAR_TYP, Prescale} !== {m_par_en, m_par_typ, m_presc}) begin
            n_bad++; $display("FAIL rand_cfg: got %b/%b/%0d expected %b/%b/%0d", PAR_EN, PAR_TYP, Prescale, m_par_en, m_par_typ, m_presc);
        end
        n_cmp++;
        if (wr_seen.size() - wbase != exp_wr.size() || rd_seen - rbase != exp_rd || tx_seen.size() - tbase != exp_tx.size()) begin
            n_bad++; $display("FAIL rand_counts: got wr=%0d rd=%0d tx=%0d expected %0d/%0d/%0d", wr_seen.size() - wbase, rd_seen - rbase, tx_seen.size() - tbase, exp_wr.size(), exp_rd, exp_tx.size());
        end else begin
            foreach (exp_wr[i]) begin
                n_cmp++;
                if (wr_seen[wbase + i] !== exp_wr[i]) begin
                    n_bad++; $display("FAIL rand_wr %0d: got %h expected %h", i, wr_seen[wbase + i], exp_wr[i]);
                end
            end
            foreach (exp_tx[i]) begin
                n_cmp++;
                if (tx_seen[tbase + i] !== exp_tx[i]) begin
                    n_bad++; $display("FAIL rand_tx %0d: got %h expected %h", i, tx_seen[tbase + i], exp_tx[i]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rx_p_data = 8'h00; rx_d_valid = 1'b0; rx_frame_err = 1'b0;
        rf_rd_data = 8'h00; rf_rd_valid = 1'b0; tx_busy = 1'b0;
        m_reset();
        @(posedge clk); #1;
        test_reset();
        test_write();
        test_read_busy();
        test_overrun();
        test_config();
        test_errors();
        test_reset_midframe();
        test_saturation();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_rx.md
# sys_ctrl_rx

Command controller that sits behind the UART receiver and turns its byte stream into register-file accesses and receiver configuration. It parses 2- and 3-byte command frames, issues single-cycle register-file write and read strobes, and forwards read data to the UART transmitter. It also owns the receiver's parity and prescale configuration and keeps a saturating error counter.

## Interface
- `ADDR_W`, 4: register-file address width, in bits.
- `TIMEOUT_CYC`, 1023: inter-byte timeout, in clk cycles. Used only with `SYS_CTRL_TIMEOUT_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-low reset.
- `rx_p_data`  in  8  received byte, valid while `rx_d_valid`.
- `rx_d_valid`  in  1  one-cycle pulse per good received byte.
- `rx_frame_err`  in  1  one-cycle pulse per byte dropped for a parity or stop error.
- `rf_addr`  out  ADDR_W  register-file address.
- `rf_wr_data`  out  8  register-file write data.
- `rf_wr_en`  out  1  one-cycle write strobe.
- `rf_rd_en`  out  1  one-cycle read strobe.
- `rf_rd_data`  in  8  read data, valid while `rf_rd_valid`.
- `rf_rd_valid`  in  1  read-data pulse.
- `tx_p_data`  out  8  byte to the transmitter.
- `tx_d_valid`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  transmitter occupied.
- `PAR_EN`  out  1  receiver parity enable.
- `PAR_TYP`  out  1  receiver parity type, 1 = even.
- `Prescale`  out  6  receiver oversampling ratio.
- `err_cnt`  out  8  saturating error count.

## Operation
- Command opcodes (first byte of a frame):
  - 0xAA, addr, data: write.
  - 0xBB, addr: read.
  - 0xCC, cfg: configure.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT, CFG_DATA.
- IDLE, on a byte:
  - 0xAA → WR_ADDR.
  - 0xBB → RD_ADDR.
  - 0xCC → CFG_DATA.
  - Any other value → stay in IDLE, `err_cnt`+1.
- Address byte checks:
  - Bits [7:ADDR_W] must be zero. Otherwise abort to IDLE and `err_cnt`+1.
  - Valid address → latched into `rf_addr`.
- WR_ADDR → WR_DATA on a valid address byte.
- WR_DATA, on a byte:
  - Latch it into `rf_wr_data`, pulse `rf_wr_en`, return to IDLE.
- RD_ADDR, on a valid address byte:
  - Pulse `rf_rd_en`, go to RD_WAIT.
- RD_WAIT:
  - On `rf_rd_valid`, capture `rf_rd_data` and go to TX_WAIT.
- TX_WAIT:
  - While `tx_busy`=1, hold.
  - In the first cycle with `tx_busy`=0, drive `tx_p_data` and pulse `tx_d_valid`, then return to IDLE.
- CFG_DATA, on a byte:
  - Load `PAR_EN`=cfg[0], `PAR_TYP`=cfg[1], `Prescale`=cfg[7:2].
  - If cfg[7:2]=0: keep the old config and `err_cnt`+1.
  - Return to IDLE in either case.
- Bytes arriving in RD_WAIT or TX_WAIT are dropped and counted as overrun (`err_cnt`+1). The state is unchanged.
- `rx_frame_err` in any state: abort to IDLE, `err_cnt`+1.
  - If it coincides with `rx_d_valid`, `rx_frame_err` wins and the byte is discarded.
- `err_cnt` saturates at 0xFF. Only reset clears it.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - `rf_addr`=0, `rf_wr_data`=0, `rf_wr_en`=0, `rf_rd_en`=0.
  - `tx_p_data`=0, `tx_d_valid`=0.
  - `PAR_EN`=1, `PAR_TYP`=0, `Prescale`=8.
  - `err_cnt`=0.
- Reset mid-frame discards the partial command. No strobe is issued in the cycle after reset releases.
- Strobe timing:
  - `rf_wr_en` rises 1 cycle after the data byte's `rx_d_valid` edge.
  - `rf_rd_en` rises 1 cycle after the address byte.
  - `rf_addr` and `rf_wr_data` are stable in the strobe cycle and hold until the next command loads them.
- Read data timing:
  - `rf_rd_valid` may arrive 1 or more cycles after `rf_rd_en`; there is no bound.
  - `tx_d_valid` asserts 1 cycle after the first cycle with `rf_rd_valid` captured and `tx_busy`=0.
- Config outputs update 1 cycle after the cfg byte. They take effect from the next received frame.

## Configuration
- `SYS_CTRL_TIMEOUT_EN` defined:
  - A counter restarts on every byte while in WR_ADDR, WR_DATA, RD_ADDR or CFG_DATA.
  - Reaching TIMEOUT_CYC with no byte → abort to IDLE, `err_cnt`+1.
  - RD_WAIT and TX_WAIT are not timed.
- Undefined: no counter. Partial frames wait indefinitely.

## Test plan
- Reset:
  - Hold `rst`=0 for 2 cycles.
  - Expect all strobes 0, `err_cnt`=0, `PAR_EN`=1, `PAR_TYP`=0, `Prescale`=8.
- Write:
  - Send 0xAA, 0x05, 0x3C.
  - Expect exactly one `rf_wr_en` pulse, 1 cycle after the third byte, with `rf_addr`=5 and `rf_wr_data`=0x3C.
- Read with busy TX:
  - Send 0xBB, 0x02. Expect `rf_rd_en` pulse, then `rf_rd_valid` with 0x5A.
  - Hold `tx_busy`=1 for 20 cycles, then release.
  - Expect one `tx_d_valid` with `tx_p_data`=0x5A 1 cycle after release.
- Config:
  - Send 0xCC, 0x42. Expect `PAR_EN`=0, `PAR_TYP`=1, `Prescale`=16.
  - Send 0xCC, 0x01. Expect config unchanged and `err_cnt`=1.
- Errors:
  - Send 0x77. Expect `err_cnt`=1.
  - Send 0xAA, then pulse `rx_frame_err`. Expect state IDLE, `err_cnt`=2, no `rf_wr_en`.
  - Send 0xAA, 0x15 (ADDR_W=4). Expect abort, `err_cnt`=3.
- Saturation and timeout:
  - Send 260 invalid opcodes. Expect `err_cnt`=0xFF.
  - With `SYS_CTRL_TIMEOUT_EN`, send 0xAA and then nothing. Expect IDLE after TIMEOUT_CYC cycles.
